// File: rtl/s1_hazard_controller.sv
// s1_hazard_controller: RAW stall/bubble control at the S1->S2 boundary using a shadow destination scoreboard
module s1_hazard_controller #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s1_valid,
  input  logic [4:0]       s1_read_sel1,
  input  logic [4:0]       s1_read_sel2,
  input  logic             s1_use_read2,
  input  logic [4:0]       s1_write_select,
  input  logic             s1_write_enable,
  output logic             stall,
  output logic             s2_bubble,
  output logic             issue,
  output logic [DEPTH-1:0] pending_mask,
  output logic [CNT_W-1:0] stall_count
);
  localparam int CHK = DEPTH - WB_BYPASS;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DEPTH-1:0][4:0] sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  m1, m2, hazard, rec;
  // compare S1 sources against older in-flight destinations (never S1's own destination)
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int k = 0; k < CHK; k++) begin
      m1 = m1 | (vld_q[k] && sel_q[k] == s1_read_sel1);
      m2 = m2 | (vld_q[k] && sel_q[k] == s1_read_sel2);
    end
    hazard = ~rst & s1_valid & ((m1 & |s1_read_sel1) | (m2 & s1_use_read2 & |s1_read_sel2));
  end
  assign stall        = hazard;
  assign issue        = ~rst & s1_valid & ~hazard;
  assign s2_bubble    = rst | hazard | ~s1_valid;
  assign pending_mask = vld_q;
  assign stall_count  = cnt_q;
  assign rec          = issue & s1_write_enable & |s1_write_select;
  // shift the scoreboard every cycle; bubbles and r0 writes enter as empty entries
  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], rec};
    sel_d = {sel_q[DEPTH-2:0], rec ? s1_write_select : 5'd0};
    cnt_d = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_s1_hazard_controller.sv
// tb_s1_hazard_controller: directed checks of stall/issue/bubble, scoreboard mask and stall counter
module tb_s1_hazard_controller;
  logic        clk = 1'b0, rst = 1'b1, v = 1'b0, u = 1'b0, e = 1'b0;
  logic [4:0]  a = '0, b = '0, w = '0;
  logic        st0, bb0, is0, st1, bb1, is1;
  logic [2:0]  pm0, pm1;
  logic [15:0] c0;
  logic [2:0]  c1;
  int          n = 0, nf = 0;

  always #5 clk = ~clk;

  s1_hazard_controller u0 (
    .clk(clk), .rst(rst), .s1_valid(v), .s1_read_sel1(a), .s1_read_sel2(b),
    .s1_use_read2(u), .s1_write_select(w), .s1_write_enable(e),
    .stall(st0), .s2_bubble(bb0), .issue(is0), .pending_mask(pm0), .stall_count(c0)
  );

  s1_hazard_controller #(.DEPTH(3), .WB_BYPASS(0), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .s1_valid(v), .s1_read_sel1(a), .s1_read_sel2(b),
    .s1_use_read2(u), .s1_write_select(w), .s1_write_enable(e),
    .stall(st1), .s2_bubble(bb1), .issue(is1), .pending_mask(pm1), .stall_count(c1)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    n++;
    assert (o === x) else begin
      nf++;
      $error("FAIL %s: got %0h, expected %0h", tag, o, x);
    end
  endtask

  task automatic ck3(input string tag, input logic s, input logic i, input logic bub);
    chk({tag, "_stall"}, 32'(st0), 32'(s));
    chk({tag, "_issue"}, 32'(is0), 32'(i));
    chk({tag, "_bubble"}, 32'(bb0), 32'(bub));
  endtask

  task automatic drv(input logic vv, input logic [4:0] aa, input logic [4:0] bv,
                     input logic uu, input logic [4:0] ww, input logic ee);
    v = vv; a = aa; b = bv; u = uu; w = ww; e = ee;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1, 6, 6, 1, 6, 1);
    @(negedge clk); ck3("rst0", 0, 0, 1);
    nxt; nxt;
    rst = 1'b0;
    drv(1, 0, 0, 0, 5, 1);
    @(negedge clk); ck3("i1", 0, 1, 0);
    nxt;
    drv(1, 5, 0, 0, 6, 1);
    @(negedge clk); ck3("dep_c1", 1, 0, 1); chk("dep_c1_pm", 32'(pm0), 32'h1);
    nxt;
    @(negedge clk); ck3("dep_c2", 1, 0, 1); chk("dep_c2_pm", 32'(pm0), 32'h2);
    nxt;
    @(negedge clk); ck3("dep_c3", 0, 1, 0); chk("dep_c3_pm", 32'(pm0), 32'h4);
    chk("dep_cnt", 32'(c0), 32'd2);
    nxt;
    drv(1, 6, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk); ck3("rst_busy", 0, 0, 1);
    nxt;
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); ck3("post_rst", 0, 0, 1);
    chk("post_rst_pm", 32'(pm0), 32'h0); chk("post_rst_cnt", 32'(c0), 32'd0);
    nxt;
    drv(1, 0, 0, 0, 7, 1);
    @(negedge clk); ck3("gap_w7", 0, 1, 0);
    nxt;
    drv(1, 1, 2, 1, 8, 1);
    @(negedge clk); ck3("gap_mid", 0, 1, 0);
    nxt;
    drv(1, 0, 7, 1, 9, 0);
    @(negedge clk); ck3("gap_s2", 1, 0, 1);
    nxt;
    @(negedge clk); ck3("gap_s2_go", 0, 1, 0); chk("gap_cnt", 32'(c0), 32'd1);
    nxt;
    drv(1, 0, 0, 0, 7, 1);
    nxt;
    drv(1, 1, 2, 1, 8, 1);
    nxt;
    drv(1, 0, 7, 0, 9, 0);
    @(negedge clk); ck3("nouse2", 0, 1, 0); chk("nouse2_pm", 32'(pm0), 32'h3);
    chk("nouse2_cnt", 32'(c0), 32'd1);
    nxt;
    drv(1, 0, 0, 0, 0, 1);
    @(negedge clk); ck3("w_r0", 0, 1, 0);
    nxt;
    drv(1, 0, 0, 1, 0, 0);
    @(negedge clk); ck3("rd_r0", 0, 1, 0); chk("r0_pm", 32'(pm0), 32'h4);
    nxt;
    drv(1, 4, 4, 1, 4, 1);
    @(negedge clk); ck3("self", 0, 1, 0);
    nxt;
    drv(1, 4, 4, 1, 0, 0);
    @(negedge clk); ck3("dual_c1", 1, 0, 1);
    nxt;
    @(negedge clk); ck3("dual_c2", 1, 0, 1);
    nxt;
    @(negedge clk); ck3("dual_go", 0, 1, 0); chk("dual_cnt", 32'(c0), 32'd3);
    nxt;
    drv(1, 0, 0, 0, 3, 1);
    nxt;
    drv(1, 3, 0, 0, 0, 0);
    @(negedge clk); ck3("mid_stall", 1, 0, 1);
    rst = 1'b1;
    nxt;
    rst = 1'b0;
    @(negedge clk); ck3("mid_rst_go", 0, 1, 0);
    chk("mid_rst_pm", 32'(pm0), 32'h0); chk("mid_rst_cnt", 32'(c0), 32'd0);
    chk("u1_rst_pm", 32'(pm1), 32'h0); chk("u1_rst_cnt", 32'(c1), 32'd0);
    nxt;
    for (int r = 1; r <= 3; r++) begin
      drv(1, 0, 0, 0, 5, 1);
      @(negedge clk); chk("nb_issue0", 32'(is0), 32'd1); chk("nb_issue1", 32'(is1), 32'd1);
      nxt;
      drv(1, 5, 0, 0, 0, 0);
      @(negedge clk); chk("nb_c1_u0", 32'(st0), 32'd1); chk("nb_c1_u1", 32'(st1), 32'd1);
      nxt;
      @(negedge clk); chk("nb_c2_u0", 32'(st0), 32'd1); chk("nb_c2_u1", 32'(st1), 32'd1);
      nxt;
      @(negedge clk); chk("nb_c3_u0", 32'(is0), 32'd1); chk("nb_c3_u1", 32'(st1), 32'd1);
      chk("nb_c3_pm1", 32'(pm1), 32'h4);
      nxt;
      @(negedge clk); chk("nb_c4_st1", 32'(st1), 32'd0); chk("nb_c4_is1", 32'(is1), 32'd1);
      chk("nb_cnt0", 32'(c0), 32'(2 * r)); chk("nb_cnt1_sat", 32'(c1), 32'((3 * r > 7) ? 7 : 3 * r));
      nxt;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, nf);
    $finish;
  end
endmodule

// File: doc/s1_hazard_controller.md
Name: s1_hazard_controller

Overview:
- Stall/bubble controller for the S1→S2 pipeline boundary of the lab CPU; the processor has no forwarding paths.
- Keeps a shadow scoreboard of destination registers in flight from S2 through writeback.
- Compares the S1 instruction's source registers against the scoreboard. On a read-after-write hazard it holds PC/S1 and injects a bubble into the S2 pipeline register.
- Sits beside the S2 register. Its outputs drive PC/S1 enable and the S2 bubble (zero write-enable) control.

Parameters:
- DEPTH, 3, number of stages from S2 through register-file writeback inclusive (S2, S3, S4).
- WB_BYPASS, 1, 1 = a register-file write in the last stage is visible to a same-cycle read, so the last stage never causes a hazard; 0 = all DEPTH stages are checked.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- s1_valid  input  1  S1 holds a real instruction.
- s1_read_sel1  input  5  source register 1 of the S1 instruction.
- s1_read_sel2  input  5  source register 2 of the S1 instruction.
- s1_use_read2  input  1  source 2 is consumed; 0 when DataSrc selects the immediate.
- s1_write_select  input  5  destination register of the S1 instruction.
- s1_write_enable  input  1  S1 instruction writes the register file.
- stall  output  1  hold PC and the S1 register this cycle.
- s2_bubble  output  1  load a NOP into S2 this cycle (S2 WriteEnable forced to 0).
- issue  output  1  S1 instruction advances into S2 this cycle.
- pending_mask  output  DEPTH  valid bit of each scoreboard entry; bit 0 corresponds to S2.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Scoreboard state:
  - entries k = 0..DEPTH-1, each holding vld[k] and sel[k]; entry k mirrors the instruction in stage S2+k.
  - every non-reset cycle the scoreboard shifts: entry k+1 <= entry k, and the top entry is discarded at writeback.
  - entry 0 <= {1, s1_write_select} when issue=1, s1_write_enable=1 and s1_write_select != 0; otherwise entry 0 <= {0, 0}. A bubble therefore records an empty entry.
  - writes to r0 are never recorded.
- Hazard check (combinational, same cycle):
  - checked range is k = 0 .. DEPTH-1-WB_BYPASS.
  - match1: s1_read_sel1 != 0 and some checked k has vld[k]=1 and sel[k]=s1_read_sel1.
  - match2: same test using s1_read_sel2, gated by s1_use_read2.
  - hazard = s1_valid & (match1 | match2).
- Outputs:
  - stall = hazard.
  - s2_bubble = hazard | ~s1_valid.
  - issue = s1_valid & ~hazard.
  - stall and issue are never asserted together; latency from inputs to outputs is zero cycles.
- Hazard resolution:
  - while stalled, the S1 inputs are held stable by the stalled S1 register; the scoreboard keeps shifting, so the hazard clears without any extra state.
  - back-to-back dependence costs DEPTH-WB_BYPASS stall cycles (2 at defaults).
  - one instruction in between costs 1 cycle; two in between cost 0.
- stall_count:
  - +1 on each cycle with stall=1.
  - saturates at all-ones; never wraps.
- Reset (rst=1 at a clock edge):
  - all vld and sel entries are cleared and stall_count is set to 0.
  - while rst is high, outputs are forced to stall=0, issue=0, s2_bubble=1.
  - reset asserted mid-stall discards all in-flight hazards. On the first cycle after reset, pending_mask=0 and no stall is raised.
- Simultaneous events:
  - a source matching several entries stalls once; the youngest entry governs when the stall clears.
  - read_sel1 = read_sel2 = pending destination is a single hazard.
  - an instruction whose source equals its own destination is not self-hazarded; only older entries are compared.
- s1_valid=0: stall=0, issue=0, and entry 0 receives an empty entry.

Test Plan:
- Reset with prior activity → pending_mask=000, stall_count=0, stall=0; during rst s2_bubble=1 and issue=0.
- Issue I1 (writes r5), then next cycle I2 (reads r5 via sel1) → stall=1 for exactly 2 cycles, issue=1 on the 3rd cycle, stall_count=2; with WB_BYPASS=0, 3 stall cycles.
- I1 writes r7, an unrelated instruction, then I3 reads r7 via sel2 with s1_use_read2=1 → 1 stall cycle; repeat with s1_use_read2=0 → 0 stall cycles.
- I1 writes r0, then I2 reads r0 → no stall, and pending_mask bit 0 = 0 after I1 issues.
- I1 writes r3, I2 reads r3 (stall begins), rst asserted on the 1st stall cycle → after reset, I2 issues immediately with stall=0.
- Force stall_count to all-ones (run 65535 stall cycles or preload in sim), then one more stall cycle → stall_count stays 16'hFFFF.
